// File: rtl/ball_motion_3d_pkg.sv
// rtl/ball_motion_3d_pkg.sv - shared types, room constants and paddle test for the 3D ball motion block
//
// Contents:
//   state_e   game state encoding driven onto the state output
//   coord_t   11-bit signed working coordinate, headroom for over/underflow before clamping
//   room, ball, paddle, serve and speed constants
//   pad_hit() paddle window test on the ball centre
package ball_motion_3d_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_PLAY      = 2'd2,
    ST_MISS      = 2'd3
  } state_e;

  typedef logic signed [10:0] coord_t;

  localparam int X_MAX        = 319;
  localparam int Y_MAX        = 239;
  localparam int Z_MAX        = 127;
  localparam int BALL_R       = 4;
  localparam int PADDLE_HALF  = 24;
  localparam int SERVE_FRAMES = 60;

  localparam logic [2:0] VX0    = 3'd2;
  localparam logic [2:0] VY0    = 3'd1;
  localparam logic [2:0] VZ0    = 3'd2;
  localparam logic [2:0] VZ_MAX = 3'd6;

  localparam logic [9:0] X_CTR = 10'(X_MAX / 2);
  localparam logic [9:0] Y_CTR = 10'(Y_MAX / 2);
  localparam logic [9:0] Z_CTR = 10'(Z_MAX / 2);

  localparam coord_t X_LO = coord_t'(BALL_R);
  localparam coord_t X_HI = coord_t'(X_MAX - BALL_R);
  localparam coord_t Y_LO = coord_t'(BALL_R);
  localparam coord_t Y_HI = coord_t'(Y_MAX - BALL_R);
  localparam coord_t Z_HI = coord_t'(Z_MAX);

  localparam logic [5:0] SERVE_LOAD = 6'(SERVE_FRAMES - 1);

  // Paddle inputs are used unclipped, so the difference can reach ~1019;
  // it still fits coord_t.
  function automatic logic pad_hit(logic [9:0] bx, logic [9:0] by,
                                   logic [9:0] px, logic [9:0] py);
    coord_t dx;
    coord_t dy;
    dx = coord_t'({1'b0, bx}) - coord_t'({1'b0, px});
    dy = coord_t'({1'b0, by}) - coord_t'({1'b0, py});
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return (dx <= coord_t'(PADDLE_HALF)) && (dy <= coord_t'(PADDLE_HALF));
  endfunction

endpackage

// File: rtl/ball_motion_3d_if.sv
// rtl/ball_motion_3d_if.sv - serve/paddle inputs and ball/state/event outputs of the 3D ball motion block
//
// Signals:
//   serve                     serve request level
//   near_pad_x/y, far_pad_x/y paddle centres (10 bit)
//   pos_x/y/z                 ball room coordinates (10 bit)
//   state                     game state (0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 MISS)
//   hit_near/hit_far          one-frame paddle return pulses
//   miss_near/miss_far        one-frame miss pulses
// Modports: master drives serve/paddles, slave (the ball block) drives the rest.
interface ball_motion_3d_if;

  logic       serve;
  logic [9:0] near_pad_x;
  logic [9:0] near_pad_y;
  logic [9:0] far_pad_x;
  logic [9:0] far_pad_y;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [9:0] pos_z;
  logic [1:0] state;
  logic       hit_near;
  logic       hit_far;
  logic       miss_near;
  logic       miss_far;

  modport master (
    output serve, near_pad_x, near_pad_y, far_pad_x, far_pad_y,
    input  pos_x, pos_y, pos_z, state, hit_near, hit_far, miss_near, miss_far
  );

  modport slave (
    input  serve, near_pad_x, near_pad_y, far_pad_x, far_pad_y,
    output pos_x, pos_y, pos_z, state, hit_near, hit_far, miss_near, miss_far
  );

endinterface

// File: rtl/ball_motion_3d_axis_step.sv
// rtl/ball_motion_3d_axis_step.sv - one frame of motion on a side-wall axis with clamp-and-reflect
//
// Ports:
//   p_i        current position
//   v_i        speed magnitude
//   dir_i      1 = increasing, 0 = decreasing
//   lo_i/hi_i  allowed position range (inclusive)
//   p_next_o   next position, always inside [lo_i, hi_i]
//   dir_next_o next direction
//   bounce_o   high when the step hit a wall this frame
module ball_axis_step
  import ball_motion_3d_pkg::*;
(
  input  logic [9:0] p_i,
  input  logic [2:0] v_i,
  input  logic       dir_i,
  input  coord_t     lo_i,
  input  coord_t     hi_i,
  output logic [9:0] p_next_o,
  output logic       dir_next_o,
  output logic       bounce_o
);

  coord_t n;

  always_comb begin
    n = dir_i ? coord_t'({1'b0, p_i}) + coord_t'(v_i)
              : coord_t'({1'b0, p_i}) - coord_t'(v_i);
    p_next_o   = n[9:0];
    dir_next_o = dir_i;
    bounce_o   = 1'b0;
    // The ball is clamped onto the wall rather than reflected past it.
    if (n > hi_i) begin
      p_next_o   = hi_i[9:0];
      dir_next_o = ~dir_i;
      bounce_o   = 1'b1;
    end else if (n < lo_i) begin
      p_next_o   = lo_i[9:0];
      dir_next_o = ~dir_i;
      bounce_o   = 1'b1;
    end
  end

endmodule

// File: rtl/ball_motion_3d.sv
// rtl/ball_motion_3d.sv - per-frame 3D Pong ball physics: serve sequencing, wall bounces, paddle hit/miss
//
// Ports:
//   Reset     asynchronous active-high reset
//   frame_clk one rising edge per video frame; downstream samples on the falling edge
//   bus       ball_motion_3d_if.slave: serve/paddles in, position/state/pulses out
module ball_motion_3d
  import ball_motion_3d_pkg::*;
(
  input  logic             Reset,
  input  logic             frame_clk,
  ball_motion_3d_if.slave  bus
);

  state_e     state_q;
  logic [9:0] x_q, y_q, z_q;
  logic [2:0] vx_q, vy_q, vz_q;
  logic       dir_x_q, dir_y_q, dir_z_q, serve_dir_q;
  logic [5:0] cnt_q;
  logic       hit_near_q, hit_far_q, miss_near_q, miss_far_q;

  logic [9:0] x_d, y_d;
  logic       dir_x_d, dir_y_d;
  logic       x_bounce, y_bounce;
  coord_t     z_n;
  logic       far_wall, near_wall, pad_ok;
  logic [2:0] vz_inc;

  ball_axis_step u_step_x (
    .p_i        (x_q),
    .v_i        (vx_q),
    .dir_i      (dir_x_q),
    .lo_i       (X_LO),
    .hi_i       (X_HI),
    .p_next_o   (x_d),
    .dir_next_o (dir_x_d),
    .bounce_o   (x_bounce)
  );

  ball_axis_step u_step_y (
    .p_i        (y_q),
    .v_i        (vy_q),
    .dir_i      (dir_y_q),
    .lo_i       (Y_LO),
    .hi_i       (Y_HI),
    .p_next_o   (y_d),
    .dir_next_o (dir_y_d),
    .bounce_o   (y_bounce)
  );

  // Paddle test uses this frame's already-updated x/y, so a ball that
  // bounces off a side wall on the end-wall frame is judged where it lands.
  always_comb begin
    z_n = dir_z_q ? coord_t'({1'b0, z_q}) + coord_t'(vz_q)
                  : coord_t'({1'b0, z_q}) - coord_t'(vz_q);
    far_wall  = dir_z_q && (z_n >= Z_HI);
    near_wall = !dir_z_q && (z_n <= coord_t'(0));
    pad_ok    = dir_z_q ? pad_hit(x_d, y_d, bus.far_pad_x, bus.far_pad_y)
                        : pad_hit(x_d, y_d, bus.near_pad_x, bus.near_pad_y);
    vz_inc    = (vz_q >= VZ_MAX) ? VZ_MAX : vz_q + 3'd1;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      x_q         <= X_CTR;
      y_q         <= Y_CTR;
      z_q         <= Z_CTR;
      vx_q        <= VX0;
      vy_q        <= VY0;
      vz_q        <= VZ0;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      dir_z_q     <= 1'b1;
      serve_dir_q <= 1'b1;
      cnt_q       <= '0;
      hit_near_q  <= 1'b0;
      hit_far_q   <= 1'b0;
      miss_near_q <= 1'b0;
      miss_far_q  <= 1'b0;
    end else begin
      hit_near_q  <= 1'b0;
      hit_far_q   <= 1'b0;
      miss_near_q <= 1'b0;
      miss_far_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.serve) begin
            state_q <= ST_COUNTDOWN;
            cnt_q   <= SERVE_LOAD;
          end
        end
        ST_COUNTDOWN: begin
          if (cnt_q == '0) begin
            state_q     <= ST_PLAY;
            dir_z_q     <= serve_dir_q;
            serve_dir_q <= ~serve_dir_q;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        ST_PLAY: begin
          x_q <= x_d;
          y_q <= y_d;
          if (x_bounce) dir_x_q <= dir_x_d;
          if (y_bounce) dir_y_q <= dir_y_d;
          if (far_wall || near_wall) begin
            z_q <= far_wall ? Z_HI[9:0] : 10'd0;
            if (pad_ok) begin
              hit_far_q  <= far_wall;
              hit_near_q <= near_wall;
              dir_z_q    <= ~dir_z_q;
              vz_q       <= vz_inc;
            end else begin
              miss_far_q  <= far_wall;
              miss_near_q <= near_wall;
              state_q     <= ST_MISS;
              cnt_q       <= SERVE_LOAD;
            end
          end else begin
            z_q <= z_n[9:0];
          end
        end
        ST_MISS: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            x_q     <= X_CTR;
            y_q     <= Y_CTR;
            z_q     <= Z_CTR;
            vx_q    <= VX0;
            vy_q    <= VY0;
            vz_q    <= VZ0;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.pos_x     = x_q;
  assign bus.pos_y     = y_q;
  assign bus.pos_z     = z_q;
  assign bus.state     = state_q;
  assign bus.hit_near  = hit_near_q;
  assign bus.hit_far   = hit_far_q;
  assign bus.miss_near = miss_near_q;
  assign bus.miss_far  = miss_far_q;

endmodule

// File: tb/tb_ball_motion_3d.sv
// tb/tb_ball_motion_3d.sv - directed self-checking bench for ball_motion_3d
module tb_ball_motion_3d;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  ball_motion_3d_if bus_if ();

  ball_motion_3d dut (
    .Reset     (reset),
    .frame_clk (clk),
    .bus       (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_pos(input string tag, input int x, input int y, input int z);
    check({tag, ".x"}, 32'(bus_if.pos_x), 32'(x));
    check({tag, ".y"}, 32'(bus_if.pos_y), 32'(y));
    check({tag, ".z"}, 32'(bus_if.pos_z), 32'(z));
  endtask

  task automatic check_pulses(input string tag, input int hn, input int hf,
                              input int mn, input int mf);
    check({tag, ".hit_near"},  32'(bus_if.hit_near),  32'(hn));
    check({tag, ".hit_far"},   32'(bus_if.hit_far),   32'(hf));
    check({tag, ".miss_near"}, 32'(bus_if.miss_near), 32'(mn));
    check({tag, ".miss_far"},  32'(bus_if.miss_far),  32'(mf));
  endtask

  task automatic set_pads(input int nx, input int ny, input int fx, input int fy);
    bus_if.near_pad_x = 10'(nx);
    bus_if.near_pad_y = 10'(ny);
    bus_if.far_pad_x  = 10'(fx);
    bus_if.far_pad_y  = 10'(fy);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    bus_if.serve = 1'b0;
    set_pads(0, 0, 223, 151);

    // Asynchronous reset between edges takes effect immediately
    #2 reset = 1'b1;
    #1;
    check_pos("reset", 159, 119, 63);
    check("reset.state", 32'(bus_if.state), 32'd0);
    check_pulses("reset", 0, 0, 0, 0);
    step(2);
    reset = 1'b0;
    step(1);
    check("idle.state", 32'(bus_if.state), 32'd0);

    // Serve and countdown: 60 frames in COUNTDOWN, position frozen
    bus_if.serve = 1'b1;
    step(1);
    bus_if.serve = 1'b0;
    check("cd.enter", 32'(bus_if.state), 32'd1);
    step(59);
    check("cd.last", 32'(bus_if.state), 32'd1);
    check_pos("cd.last", 159, 119, 63);
    step(1);
    check("play.enter", 32'(bus_if.state), 32'd2);
    check_pos("play.enter", 159, 119, 63);
    step(1);
    check_pos("play.k1", 161, 120, 65);

    // Far wall at k=32: z 125 -> 127, paddle centred on (223,151)
    step(30);
    check_pos("play.k31", 221, 150, 125);
    step(1);
    check_pos("far1", 223, 151, 127);
    check_pulses("far1", 0, 1, 0, 0);
    set_pads(309, 194, 0, 0);
    step(1);
    check("far1.after.z", 32'(bus_if.pos_z), 32'd124);
    check_pulses("far1.after", 0, 0, 0, 0);
    step(1);
    check("vz3.z", 32'(bus_if.pos_z), 32'd121);

    // Near wall at k=75: z 1 -> 0, vz 3 -> 4
    step(41);
    check_pos("near1", 309, 194, 0);
    check_pulses("near1", 1, 0, 0, 0);
    check("near1.state", 32'(bus_if.state), 32'd2);
    set_pads(0, 0, 259, 226);
    step(1);
    check_pos("near1.after", 311, 195, 4);

    // x reaches 315 exactly (no bounce), then clamps and reflects
    step(2);
    check_pos("x.edge", 315, 197, 12);
    step(1);
    check_pos("x.clamp", 315, 198, 16);
    step(1);
    check_pos("x.reflect", 313, 199, 20);

    // Far hit at k=107, vz 4 -> 5
    step(27);
    check_pos("far2", 259, 226, 127);
    check("far2.hit", 32'(bus_if.hit_far), 32'd1);
    set_pads(207, 219, 0, 0);
    step(1);
    check("vz5.z", 32'(bus_if.pos_z), 32'd122);

    // Near hit at k=133 after the y wall bounce at k=117, vz 5 -> 6
    step(25);
    check_pos("near2", 207, 219, 0);
    check("near2.hit", 32'(bus_if.hit_near), 32'd1);
    set_pads(0, 0, 187, 197);
    step(1);
    check("vz6.z", 32'(bus_if.pos_z), 32'd6);

    // Far hit at k=155 with paddle exactly PADDLE_HALF away in x; vz saturates at 6
    step(21);
    check_pos("far3", 163, 197, 127);
    check_pulses("far3", 0, 1, 0, 0);
    set_pads(149, 175, 0, 0);
    step(1);
    check("vzsat.z", 32'(bus_if.pos_z), 32'd121);

    // Near paddle offset 30 in x -> miss at k=177
    step(20);
    check("premiss.z", 32'(bus_if.pos_z), 32'd1);
    step(1);
    check_pos("miss", 119, 175, 0);
    check_pulses("miss", 0, 0, 1, 0);
    check("miss.state", 32'(bus_if.state), 32'd3);

    // MISS hold with serve asserted: ignored, position frozen for 60 frames
    bus_if.serve = 1'b1;
    step(1);
    check("miss.hold.state", 32'(bus_if.state), 32'd3);
    check("miss.hold.pulse", 32'(bus_if.miss_near), 32'd0);
    step(10);
    check("miss.serve.state", 32'(bus_if.state), 32'd3);
    bus_if.serve = 1'b0;
    step(48);
    check("miss.last.state", 32'(bus_if.state), 32'd3);
    check_pos("miss.last", 119, 175, 0);
    step(1);
    check("idle2.state", 32'(bus_if.state), 32'd0);
    check_pos("idle2", 159, 119, 63);

    // Second serve goes toward the near wall at VZ0; x/y keep their reflected directions
    bus_if.serve = 1'b1;
    step(1);
    bus_if.serve = 1'b0;
    check("cd2.state", 32'(bus_if.state), 32'd1);
    step(60);
    check("play2.state", 32'(bus_if.state), 32'd2);
    step(1);
    check_pos("play2.k1", 157, 118, 61);
    step(1);
    check("play2.k2.z", 32'(bus_if.pos_z), 32'd59);

    // Reset mid-frame during PLAY
    reset = 1'b1;
    #1;
    check_pos("reset2", 159, 119, 63);
    check("reset2.state", 32'(bus_if.state), 32'd0);
    #2 reset = 1'b0;
    step(1);
    check("reset2.idle", 32'(bus_if.state), 32'd0);

    // After reset the serve direction is far again, with VZ0 and + x/y
    bus_if.serve = 1'b1;
    step(1);
    bus_if.serve = 1'b0;
    step(60);
    check("play3.state", 32'(bus_if.state), 32'd2);
    step(1);
    check_pos("play3.k1", 161, 120, 65);
    step(1);
    check("play3.k2.z", 32'(bus_if.pos_z), 32'd67);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
